// File: rtl/adc_spi_pkg.sv
// Shared types and default constants for the ADC SPI reader.
package adc_spi_pkg;

  localparam int DEFAULT_DATA_WIDTH  = 24;
  localparam int DEFAULT_HALF_PERIOD = 2;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CS_SETUP = 2'd1,
    ST_SHIFT    = 2'd2,
    ST_CS_HOLD  = 2'd3
  } state_t;

endpackage

// File: rtl/spi_clk_div.sv
// SCK half-period tick generator; the count restarts whenever the enable drops.
module spi_clk_div
  import adc_spi_pkg::*;
#(
  parameter int HALF_PERIOD = DEFAULT_HALF_PERIOD
) (
  input  logic aclk,
  input  logic areset,
  input  logic en,
  output logic tick
);

  localparam logic [7:0] LAST = 8'(HALF_PERIOD - 1);

  logic [7:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      cnt <= 8'd0;
    end else if (!en || tick) begin
      cnt <= 8'd0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/adc_spi_reader.sv
// ADC SPI reader: runs one SPI mode-0 read per trigger and presents the
// sign-extended sample in a single-entry AXI-Stream output register.
module adc_spi_reader
  import adc_spi_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int HALF_PERIOD = DEFAULT_HALF_PERIOD
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        trigger,
  output logic        spi_cs_n,
  output logic        spi_sck,
  input  logic        spi_sdi,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        busy,
  output logic        overflow,
  output logic        missed_trigger,
  input  logic        status_clear,
  output state_t      state_dbg
);

  localparam int               CNT_W     = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_WIDTH);
  localparam logic [7:0]       HOLD_LAST = 8'(HALF_PERIOD - 1);

  state_t                state, state_nx;
  logic                  tick, div_en, rise, fall, frame_done;
  logic [CNT_W-1:0]      bit_cnt;
  logic [7:0]            hold_cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic [31:0]           sample_ext;

  assign div_en     = (state == ST_CS_SETUP) || (state == ST_SHIFT);
  assign fall       = (state == ST_SHIFT) && tick && spi_sck;
  assign busy       = (state != ST_IDLE);
  assign state_dbg  = state;
  assign sample_ext = 32'($signed(shreg));

  spi_clk_div #(.HALF_PERIOD(HALF_PERIOD)) u_clk_div (
    .aclk   (aclk),
    .areset (areset),
    .en     (div_en),
    .tick   (tick)
  );

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // A tick while SCK is low either raises SCK for the next bit or, once all
  // bits are in, closes the final low half-period and ends the frame.
  always_comb begin
    state_nx   = state;
    rise       = 1'b0;
    frame_done = 1'b0;
    case (state)
      ST_IDLE:     if (trigger) state_nx = ST_CS_SETUP;
      ST_CS_SETUP: if (tick) begin
                     rise     = 1'b1;
                     state_nx = ST_SHIFT;
                   end
      ST_SHIFT:    if (tick && !spi_sck) begin
                     if (bit_cnt == LAST_BIT) begin
                       frame_done = 1'b1;
                       state_nx   = ST_CS_HOLD;
                     end else begin
                       rise = 1'b1;
                     end
                   end
      ST_CS_HOLD:  if (hold_cnt == HOLD_LAST) state_nx = ST_IDLE;
      default:     state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      spi_cs_n <= 1'b1;
      spi_sck  <= 1'b0;
      bit_cnt  <= '0;
      hold_cnt <= 8'd0;
      shreg    <= '0;
    end else begin
      if (state == ST_IDLE && trigger) begin
        spi_cs_n <= 1'b0;
        bit_cnt  <= '0;
      end
      if (rise) begin
        spi_sck <= 1'b1;
        shreg   <= {shreg[DATA_WIDTH-2:0], spi_sdi};
        bit_cnt <= bit_cnt + CNT_W'(1);
      end else if (fall) begin
        spi_sck <= 1'b0;
      end
      if (frame_done) spi_cs_n <= 1'b1;
      hold_cnt <= (state == ST_CS_HOLD) ? hold_cnt + 8'd1 : 8'd0;
    end
  end

  // Stream handshake: a word transfers on any edge where tvalid and tready are
  // both high; tvalid never waits on tready and tdata is frozen while tvalid=1.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      m_axis_tdata   <= 32'd0;
      m_axis_tvalid  <= 1'b0;
      overflow       <= 1'b0;
      missed_trigger <= 1'b0;
    end else begin
      if (frame_done && (!m_axis_tvalid || m_axis_tready)) begin
        m_axis_tdata  <= sample_ext;
        m_axis_tvalid <= 1'b1;
      end else if (m_axis_tvalid && m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
      if (frame_done && m_axis_tvalid && !m_axis_tready) overflow <= 1'b1;
      else if (status_clear)                             overflow <= 1'b0;
      if (trigger && state != ST_IDLE) missed_trigger <= 1'b1;
      else if (status_clear)           missed_trigger <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adc_spi_reader.sv
// Self-checking bench for adc_spi_reader: table vectors, directed corner
// sequences and randomized traffic against a cycle-count reference model.
module tb_adc_spi_reader;
  import adc_spi_pkg::*;

  localparam int D   = 24;
  localparam int H   = 2;
  localparam int LAT = 1 + H * (2 * D + 1);
  localparam int D2  = 16;
  localparam int LAT2 = 1 + 1 * (2 * D2 + 1);

  // ---------------- clock / reset ----------------
  logic aclk = 1'b0;
  logic areset = 1'b1;
  always #5 aclk = ~aclk;

  // ---------------- DUT (defaults) ----------------
  logic        trigger = 1'b0, status_clear = 1'b0, m_axis_tready = 1'b1;
  logic        spi_cs_n, spi_sck, spi_sdi, m_axis_tvalid, busy, overflow, missed_trigger;
  logic [31:0] m_axis_tdata;
  state_t      state_dbg;

  adc_spi_reader dut (
    .aclk(aclk), .areset(areset), .trigger(trigger),
    .spi_cs_n(spi_cs_n), .spi_sck(spi_sck), .spi_sdi(spi_sdi),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .busy(busy), .overflow(overflow), .missed_trigger(missed_trigger),
    .status_clear(status_clear), .state_dbg(state_dbg)
  );

  // ---------------- DUT (16 bits, half period 1) ----------------
  logic        b_trigger = 1'b0, b_clear = 1'b0, b_tready = 1'b1;
  logic        b_cs_n, b_sck, b_sdi, b_tvalid, b_busy, b_ovf, b_miss;
  logic [31:0] b_tdata;
  state_t      b_state;

  adc_spi_reader #(.DATA_WIDTH(D2), .HALF_PERIOD(1)) dut_b (
    .aclk(aclk), .areset(areset), .trigger(b_trigger),
    .spi_cs_n(b_cs_n), .spi_sck(b_sck), .spi_sdi(b_sdi),
    .m_axis_tdata(b_tdata), .m_axis_tvalid(b_tvalid), .m_axis_tready(b_tready),
    .busy(b_busy), .overflow(b_ovf), .missed_trigger(b_miss),
    .status_clear(b_clear), .state_dbg(b_state)
  );

  // ---------------- ADC models: word latched at CS fall, next bit after SCK fall ----------------
  logic [31:0] adc_word = 32'd0, adc_lat = 32'd0;
  int          adc_idx = 0;
  always @(negedge spi_cs_n) begin adc_lat = adc_word; adc_idx = D - 1; end
  always @(negedge spi_sck) if (spi_cs_n === 1'b0 && adc_idx > 0) adc_idx--;
  assign spi_sdi = adc_lat[adc_idx];

  logic [31:0] b_word = 32'd0, b_lat = 32'd0;
  int          b_idx = 0;
  always @(negedge b_cs_n) begin b_lat = b_word; b_idx = D2 - 1; end
  always @(negedge b_sck) if (b_cs_n === 1'b0 && b_idx > 0) b_idx--;
  assign b_sdi = b_lat[b_idx];

  int rises = 0, rises_cs_hi = 0;
  always @(posedge spi_sck) begin
    rises++;
    if (spi_cs_n !== 1'b0) rises_cs_hi++;
  end

  // ---------------- scoreboard helpers ----------------
  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] sext(input logic [31:0] w, input int d);
    longint v;
    v = longint'(w) & ((longint'(1) << d) - 1);
    if (v >= (longint'(1) << (d - 1))) v = v - (longint'(1) << d);
    return 32'(v);
  endfunction

  // ---------------- reference model: frame timing by cycle arithmetic ----------------
  int          edge_n = 0, accept_from = 0, done_at = -1, fr_start = -1;
  logic [31:0] in_flight = 32'd0, m_word = 32'd0;
  bit          m_full = 1'b0, m_ovf = 1'b0, m_miss = 1'b0;
  logic [31:0] exp_q[$];

  always @(posedge aclk) begin
    bit ovf_set, miss_set;
    edge_n++;
    ovf_set  = 1'b0;
    miss_set = 1'b0;
    if (areset) begin
      accept_from = edge_n + 1;
      done_at = -1; fr_start = -1;
      m_full = 1'b0; m_word = 32'd0; m_ovf = 1'b0; m_miss = 1'b0;
    end else begin
      if (edge_n == done_at) begin
        if (!m_full || m_axis_tready) begin
          m_word = in_flight;
          m_full = 1'b1;
          exp_q.push_back(in_flight);
        end else begin
          ovf_set = 1'b1;
        end
      end else if (m_full && m_axis_tready) begin
        m_full = 1'b0;
      end
      if (trigger) begin
        if (edge_n >= accept_from) begin
          fr_start    = edge_n;
          done_at     = edge_n + LAT - 1;
          accept_from = edge_n + H * (2 * D + 2) + 1;
          in_flight   = sext(adc_word, D);
        end else begin
          miss_set = 1'b1;
        end
      end
      m_ovf  = ovf_set  | (m_ovf  & !status_clear);
      m_miss = miss_set | (m_miss & !status_clear);
    end
  end

  always @(negedge aclk) begin
    if (!areset) begin
      chk("tvalid", {31'd0, m_axis_tvalid}, {31'd0, m_full});
      chk("tdata", m_axis_tdata, m_word);
      chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
      chk("missed", {31'd0, missed_trigger}, {31'd0, m_miss});
      chk("busy", {31'd0, busy}, {31'd0, (edge_n + 1 < accept_from)});
      chk("cs_n", {31'd0, spi_cs_n}, {31'd0, !(fr_start >= 0 && edge_n >= fr_start && edge_n < done_at)});
    end
  end

  // Words accepted by the stream must be exactly the model's words, in order.
  always @(posedge aclk) begin
    if (!areset && m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
      if (exp_q.size() == 0) chk("stream_extra", m_axis_tdata, 32'hDEAD_BEEF);
      else                   chk("stream_word", m_axis_tdata, exp_q.pop_front());
    end
  end
  always @(posedge aclk) if (areset) exp_q.delete();

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 1000) begin step(); n++; end
    chk("idle_reached", {31'd0, busy}, 32'd0);
  endtask

  task automatic start_frame(input logic [31:0] w);
    wait_idle();
    adc_word = w;
    trigger  = 1'b1;
    step();
    trigger  = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!m_axis_tvalid && lat < 400) begin step(); lat++; end
  endtask

  typedef struct {
    logic [31:0] word;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    vecs[0] = '{32'h0080_0001, 32'hFF80_0001};
    vecs[1] = '{32'h007F_FFFF, 32'h007F_FFFF};
    vecs[2] = '{32'h0000_0000, 32'h0000_0000};
    vecs[3] = '{32'h00FF_FFFF, 32'hFFFF_FFFF};
    vecs[4] = '{32'h0012_3456, 32'h0012_3456};
    vecs[5] = '{32'h00A5_A5A5, 32'hFFA5_A5A5};

    // reset and reset values
    repeat (3) step();
    areset = 1'b0;
    step();
    chk("rst_cs_n", {31'd0, spi_cs_n}, 32'd1);
    chk("rst_sck", {31'd0, spi_sck}, 32'd0);
    chk("rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    chk("rst_tdata", m_axis_tdata, 32'd0);
    chk("rst_flags", {30'd0, overflow, missed_trigger}, 32'd0);
    chk("rst_state", {30'd0, state_dbg}, 32'd0);

    // table: back-to-back frames with tready high
    m_axis_tready = 1'b1;
    foreach (vecs[i]) begin
      rises = 0; rises_cs_hi = 0;
      start_frame(vecs[i].word);
      wait_valid(lat);
      chk("vec_tdata", m_axis_tdata, vecs[i].exp);
      chk("vec_latency", lat, LAT);
      wait_idle();
      chk("vec_sck_rises", rises, D);
      chk("vec_sck_cs_high", rises_cs_hi, 0);
    end
    chk("vec_no_flags", {30'd0, overflow, missed_trigger}, 32'd0);

    // overflow: two frames with tready low, second dropped
    m_axis_tready = 1'b0;
    start_frame(32'h0000_1234);
    wait_valid(lat);
    start_frame(32'h0055_5555);
    wait_idle();
    chk("ovf_tdata_held", m_axis_tdata, 32'h0000_1234);
    chk("ovf_tvalid_held", {31'd0, m_axis_tvalid}, 32'd1);
    chk("ovf_set", {31'd0, overflow}, 32'd1);
    status_clear = 1'b1; step(); status_clear = 1'b0;
    chk("ovf_cleared", {31'd0, overflow}, 32'd0);

    // completion coinciding with handshake of the held word
    start_frame(32'h0080_0000);
    repeat (LAT - 2) step();
    m_axis_tready = 1'b1;
    step();
    chk("coinc_tvalid", {31'd0, m_axis_tvalid}, 32'd1);
    chk("coinc_tdata", m_axis_tdata, 32'hFF80_0000);
    chk("coinc_no_ovf", {31'd0, overflow}, 32'd0);
    step();
    chk("coinc_drained", {31'd0, m_axis_tvalid}, 32'd0);

    // triggers while busy; the second coincides with status_clear
    rises = 0;
    start_frame(32'h0033_CC33);
    repeat (9) step();
    trigger = 1'b1; step(); trigger = 1'b0;
    repeat (39) step();
    trigger = 1'b1; status_clear = 1'b1; step();
    trigger = 1'b0; status_clear = 1'b0;
    chk("miss_set_wins", {31'd0, missed_trigger}, 32'd1);
    wait_valid(lat);
    chk("miss_tdata", m_axis_tdata, 32'h0033_CC33);
    wait_idle();
    chk("miss_sck_rises", rises, D);
    status_clear = 1'b1; step(); status_clear = 1'b0;
    chk("miss_cleared", {31'd0, missed_trigger}, 32'd0);

    // reset mid-frame, then immediate trigger after release
    rises = 0;
    start_frame(32'h00F0_0F0F);
    for (int n = 0; n < 300 && rises < 10; n++) step();
    areset = 1'b1;
    #1;
    chk("arst_cs_n", {31'd0, spi_cs_n}, 32'd1);
    chk("arst_sck", {31'd0, spi_sck}, 32'd0);
    chk("arst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    step(); step();
    areset = 1'b0;
    rises = 0;
    start_frame(32'h0000_0F0F);
    wait_valid(lat);
    chk("arst_next_tdata", m_axis_tdata, 32'h0000_0F0F);
    chk("arst_next_latency", lat, LAT);
    wait_idle();
    chk("arst_next_rises", rises, D);

    // narrow instance: 16 bits, half period 1
    for (int i = 0; i < 2; i++) begin
      int l2;
      b_word = (i == 0) ? 32'h0000_8000 : 32'h0000_7FFF;
      b_trigger = 1'b1; step(); b_trigger = 1'b0;
      l2 = 1;
      while (!b_tvalid && l2 < 200) begin step(); l2++; end
      chk("w16_latency", l2, LAT2);
      chk("w16_tdata", b_tdata, (i == 0) ? 32'hFFFF_8000 : 32'h0000_7FFF);
      repeat (4) step();
    end

    // randomized traffic against the model
    for (int n = 0; n < 5000; n++) begin
      trigger       = ($urandom_range(0, 24) == 0);
      m_axis_tready = ($urandom_range(0, 3) != 0);
      status_clear  = ($urandom_range(0, 59) == 0);
      adc_word      = $urandom & 32'h00FF_FFFF;
      step();
    end
    trigger = 1'b0; status_clear = 1'b0; m_axis_tready = 1'b1;
    wait_idle();
    repeat (4) step();
    chk("rand_queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/adc_spi_reader.md
ADC_SPI_READER -- requirements
Module: adc_spi_reader

Interface
REQ-001 Parameter DATA_WIDTH, 24, ADC conversion bits per frame; legal range 8..32.
REQ-002 Parameter HALF_PERIOD, 2, aclk cycles per SCK half-period; legal range 1..255.
REQ-003 Port aclk  input  1  single clock; all logic on its rising edge.
REQ-004 Port areset  input  1  reset, asynchronous, active-high.
REQ-005 Port trigger  input  1  conversion start request, sampled per aclk cycle.
REQ-006 Port spi_cs_n  output  1  ADC chip select, active-low.
REQ-007 Port spi_sck  output  1  SPI clock, mode 0, idles low.
REQ-008 Port spi_sdi  input  1  ADC serial data, MSB first.
REQ-009 Port m_axis_tdata  output  32  sample, sign-extended from DATA_WIDTH to 32 bits.
REQ-010 Port m_axis_tvalid  output  1  AXI-Stream valid.
REQ-011 Port m_axis_tready  input  1  AXI-Stream ready from downstream packetizer.
REQ-012 Port busy  output  1  high whenever state is not IDLE.
REQ-013 Port overflow  output  1  sticky: a completed sample was dropped.
REQ-014 Port missed_trigger  output  1  sticky: a trigger arrived while busy.
REQ-015 Port status_clear  input  1  one-cycle pulse clearing both sticky flags.

Function
REQ-016 FSM states IDLE, CS_SETUP, SHIFT, CS_HOLD; any other encoding returns to IDLE.
REQ-017 IDLE + trigger=1 at edge T: spi_cs_n=0 from T+1, enter CS_SETUP.
REQ-018 CS_SETUP lasts HALF_PERIOD cycles with spi_sck=0, then enters SHIFT.
REQ-019 SHIFT: spi_sck toggles every HALF_PERIOD cycles, starting high; exactly DATA_WIDTH rising edges per frame.
REQ-020 spi_sdi captured into shift register on the aclk edge at which spi_sck goes 0->1; first captured bit = MSB.
REQ-021 After the last SCK low half-period completes: spi_cs_n=1, spi_sck=0, sample presented, enter CS_HOLD.
REQ-022 Latency trigger edge to m_axis_tvalid=1 = 1 + HALF_PERIOD*(2*DATA_WIDTH+1) cycles (defaults: 99).
REQ-023 CS_HOLD lasts HALF_PERIOD cycles, then IDLE; back-to-back trigger accepted on the first IDLE cycle.
REQ-024 Output: single-entry register; tdata stable and tvalid held until tvalid&tready handshake.
REQ-025 Sample completion with tvalid=1 and tready=0: new sample discarded, old word kept, overflow set.
REQ-026 Sample completion coinciding with handshake on old word: new word loaded, tvalid stays 1, no overflow.
REQ-027 trigger=1 in any state other than IDLE: ignored, missed_trigger set; frame in progress unaffected.
REQ-028 status_clear and a flag set event in the same cycle: flag ends set.
REQ-029 tvalid never depends combinationally on tready; no output combinationally depends on any input.

Reset
REQ-030 areset=1 asynchronously forces: state IDLE, spi_cs_n=1, spi_sck=0, m_axis_tvalid=0, m_axis_tdata=0, busy=0, overflow=0, missed_trigger=0, counters 0.
REQ-031 Reset mid-frame aborts the frame; no partial word emitted after release.
REQ-032 First trigger accepted on the first aclk edge after areset deasserts.

Structure
REQ-033 Package adc_spi_pkg holds the FSM state enum and default constants for DATA_WIDTH and HALF_PERIOD.
REQ-034 Sub-module spi_clk_div generates the SCK half-period tick from HALF_PERIOD; enabled only in CS_SETUP/SHIFT.
REQ-035 Bit counter width = $clog2(DATA_WIDTH+1); half-period counter width 8.

Verification
REQ-036 Defaults, ADC model returns 24'h800001, tready=1 -> tdata=32'hFF800001, tvalid at 99 cycles after trigger, 24 SCK rising edges, cs_n low throughout.
REQ-037 ADC returns 24'h7FFFFF then 24'h000000 on back-to-back triggers -> 32'h007FFFFF then 32'h00000000, in order, no flags set.
REQ-038 tready=0, two frames completed -> first word held, second dropped, overflow=1; status_clear -> overflow=0.
REQ-039 Trigger pulses at 10 and 50 cycles after first trigger -> single frame, missed_trigger=1, 24 SCK edges only.
REQ-040 areset asserted after 10 SCK edges -> cs_n=1, sck=0, tvalid=0 immediately; next frame after release returns correct full word.
REQ-041 DATA_WIDTH=16, HALF_PERIOD=1, sample 16'h8000 -> tdata=32'hFFFF8000, latency 34 cycles.
